// File: rtl/gpio_bus_decoder.sv
// GPIO-to-register-bus decoder: synchronizes a processor GPIO word, turns
// each rising edge of the write strobe into an address/data command,
// buffers commands in a small FIFO, and presents them on a valid/ready bus.
module gpio_bus_decoder #(
    parameter int GPIO_W     = 25,
    parameter int W_CLK_BIT  = 24,
    parameter int ADDR_W     = 16,
    parameter int DATA_W     = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [GPIO_W-1:0] gpio_in,
    output logic [ADDR_W-1:0] reg_addr,
    output logic [DATA_W-1:0] reg_data,
    output logic              reg_wr_valid,
    input  logic              reg_wr_ready,
    output logic              run_trig_pulse,
    output logic              halt_pulse,
    output logic              overflow,
    output logic [15:0]       wr_count
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);

    typedef enum logic {DISARMED, ARMED} state_t;

    logic [GPIO_W-1:0] s1, s2;
    logic              strobe_prev;
    logic [1:0]        fill;
    state_t            state;

    logic [ADDR_W-1:0] addr_mem [FIFO_DEPTH];
    logic [DATA_W-1:0] data_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr, rd_ptr, rd_next;
    logic [CNT_W-1:0]  count, count_next;
    logic [15:0]       wr_cnt;

    logic              wr_event, push_ok, pop, full;
    logic [ADDR_W-1:0] cap_addr, head_addr;
    logic [DATA_W-1:0] cap_data, head_data;

    assign cap_addr = s2[ADDR_W-1:0];
    assign cap_data = s2[ADDR_W +: DATA_W];
    assign wr_count = wr_cnt;

    // Two-flop synchronizer on the whole GPIO word
    always_ff @(posedge clk) begin
        if (rst) begin
            s1 <= '0;
            s2 <= '0;
        end else begin
            s1 <= gpio_in;
            s2 <= s1;
        end
    end

    // Arming FSM and strobe edge history; 'fill' keeps the reset-cleared
    // synchronizer contents from counting as a genuine low strobe sample
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= DISARMED;
            strobe_prev <= 1'b0;
            fill        <= 2'd0;
        end else begin
            strobe_prev <= s2[W_CLK_BIT];
            if (fill != 2'd2)
                fill <= fill + 2'd1;
            if (state == DISARMED && fill == 2'd2 && !s2[W_CLK_BIT])
                state <= ARMED;
        end
    end

    assign wr_event = (state == ARMED) && s2[W_CLK_BIT] && !strobe_prev;
    assign pop      = reg_wr_valid && reg_wr_ready;
    assign full     = (count == FULL_CNT);
    assign push_ok  = wr_event && (!full || pop);
    assign rd_next  = pop ? rd_ptr + 1'b1 : rd_ptr;

    // Next occupancy and the entry that will sit at the head after this edge
    always_comb begin
        count_next = count;
        if (push_ok && !pop)
            count_next = count + 1'b1;
        else if (!push_ok && pop)
            count_next = count - 1'b1;
        head_addr = addr_mem[rd_next];
        head_data = data_mem[rd_next];
        if (push_ok && wr_ptr == rd_next) begin
            head_addr = cap_addr;
            head_data = cap_data;
        end
    end

    // Command storage
    always_ff @(posedge clk) begin
        if (push_ok) begin
            addr_mem[wr_ptr] <= cap_addr;
            data_mem[wr_ptr] <= cap_data;
        end
    end

    // FIFO control, registered bus outputs, counters and trigger pulses
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr         <= '0;
            rd_ptr         <= '0;
            count          <= '0;
            reg_wr_valid   <= 1'b0;
            reg_addr       <= '0;
            reg_data       <= '0;
            overflow       <= 1'b0;
            wr_cnt         <= 16'h0000;
            run_trig_pulse <= 1'b0;
            halt_pulse     <= 1'b0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
                wr_cnt <= wr_cnt + 16'h0001;
            end
            rd_ptr       <= rd_next;
            count        <= count_next;
            reg_wr_valid <= (count_next != '0);
            if (count_next != '0) begin
                reg_addr <= head_addr;
                reg_data <= head_data;
            end
            if (wr_event && !push_ok)
                overflow <= 1'b1;
            run_trig_pulse <= pop && (reg_addr == ADDR_W'(0));
            halt_pulse     <= pop && (reg_addr == ADDR_W'(2));
        end
    end

endmodule

// File: tb/tb_gpio_bus_decoder.sv
// Scoreboard bench for gpio_bus_decoder: the stimulus side pushes the
// commands the FIFO should accept, a monitor pops them on every handshake.
module tb_gpio_bus_decoder;

    localparam int DEPTH = 4;

    typedef struct packed {
        logic [15:0] a;
        logic [7:0]  d;
    } cmd_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [24:0] gpio_in = '0;
    logic        ready = 1'b0;
    logic [15:0] reg_addr;
    logic [7:0]  reg_data;
    logic        reg_wr_valid;
    logic        run_trig_pulse;
    logic        halt_pulse;
    logic        overflow;
    logic [15:0] wr_count;

    cmd_t        exp_q[$];
    int          checks = 0;
    int          errors = 0;
    logic [15:0] m_cnt = 16'h0000;
    logic        m_ovf = 1'b0;
    bit          rand_ready = 1'b0;
    int          run_seen = 0;
    int          halt_seen = 0;
    int          run_exp_n = 0;
    int          halt_exp_n = 0;
    bit          exp_run = 1'b0;
    bit          exp_halt = 1'b0;

    gpio_bus_decoder dut (
        .clk            (clk),
        .rst            (rst),
        .gpio_in        (gpio_in),
        .reg_addr       (reg_addr),
        .reg_data       (reg_data),
        .reg_wr_valid   (reg_wr_valid),
        .reg_wr_ready   (ready),
        .run_trig_pulse (run_trig_pulse),
        .halt_pulse     (halt_pulse),
        .overflow       (overflow),
        .wr_count       (wr_count)
    );

    always #5 clk = ~clk;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endfunction

    // Monitor: samples mid-cycle, compares beats and pulses against the model
    initial begin : monitor
        cmd_t e;
        forever begin
            @(negedge clk);
            #2;
            if (rst) begin
                exp_run  = 1'b0;
                exp_halt = 1'b0;
            end else begin
                chk("run_pulse", run_trig_pulse, exp_run);
                chk("halt_pulse", halt_pulse, exp_halt);
                if (run_trig_pulse) run_seen++;
                if (halt_pulse) halt_seen++;
                exp_run  = 1'b0;
                exp_halt = 1'b0;
                if (reg_wr_valid) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_valid: addr %0h data %0h with empty scoreboard",
                                 reg_addr, reg_data);
                    end else begin
                        e = exp_q[0];
                        chk("head_addr", reg_addr, e.a);
                        chk("head_data", reg_data, e.d);
                        if (ready) begin
                            void'(exp_q.pop_front());
                            exp_run  = (e.a == 16'h0000);
                            exp_halt = (e.a == 16'h0002);
                        end
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(negedge clk);
        if (rand_ready) ready = ($urandom_range(0, 3) != 0);
    endtask

    task automatic do_reset();
        tick();
        rst = 1'b1;
        exp_q.delete();
        m_cnt = 16'h0000;
        m_ovf = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    // Model push: the FIFO accepts a command unless it already holds DEPTH
    task automatic model_push(input logic [15:0] a, input logic [7:0] d, input bit simul_pop);
        cmd_t c;
        c.a = a;
        c.d = d;
        if (exp_q.size() < DEPTH || simul_pop) begin
            exp_q.push_back(c);
            m_cnt = m_cnt + 16'h0001;
            if (a == 16'h0000) run_exp_n++;
            if (a == 16'h0002) halt_exp_n++;
        end else begin
            m_ovf = 1'b1;
        end
    endtask

    task automatic wr(input logic [15:0] a, input logic [7:0] d, input int hold);
        tick();
        gpio_in = {1'b0, d, a};
        tick();
        gpio_in = {1'b1, d, a};
        model_push(a, d, 1'b0);
        repeat (hold) tick();
    endtask

    task automatic drain(input string name);
        int n = 0;
        while (exp_q.size() != 0 && n < 500) begin
            tick();
            n++;
        end
        tick();
        chk(name, exp_q.size(), 0);
        chk({name, "_valid_low"}, reg_wr_valid, 1'b0);
    endtask

    initial begin : stim
        logic [15:0] a;
        int          n;

        // Reset state
        tick();
        tick();
        chk("rst_valid", reg_wr_valid, 1'b0);
        chk("rst_addr", reg_addr, 16'h0000);
        chk("rst_data", reg_data, 8'h00);
        chk("rst_overflow", overflow, 1'b0);
        chk("rst_wr_count", wr_count, 16'h0000);
        chk("rst_pulses", {run_trig_pulse, halt_pulse}, 2'b00);
        rst = 1'b0;
        repeat (3) tick();

        // Single write and first-beat latency
        ready = 1'b1;
        tick();
        gpio_in = {1'b0, 8'hA5, 16'h000C};
        tick();
        gpio_in = {1'b1, 8'hA5, 16'h000C};
        model_push(16'h000C, 8'hA5, 1'b0);
        tick();
        tick();
        chk("lat_edge2_valid", reg_wr_valid, 1'b0);
        tick();
        chk("lat_edge3_valid", reg_wr_valid, 1'b1);
        chk("single_addr", reg_addr, 16'h000C);
        chk("single_data", reg_data, 8'hA5);
        tick();
        chk("single_one_beat", reg_wr_valid, 1'b0);
        tick();
        chk("single_wr_count", wr_count, 16'h0001);

        // Backpressure: four held in order, fifth dropped
        do_reset();
        ready = 1'b0;
        for (int i = 0; i < 5; i++)
            wr(16'h0100 + 16'(i), 8'h10 + 8'(i), 4);
        chk("bp_overflow", overflow, 1'b1);
        chk("bp_wr_count", wr_count, 16'd4);
        chk("bp_model_ovf", overflow, m_ovf);
        ready = 1'b1;
        drain("bp_drain");
        chk("bp_overflow_sticky", overflow, 1'b1);

        // Full FIFO with a pop on the same edge as the push
        do_reset();
        ready = 1'b0;
        for (int i = 0; i < 4; i++)
            wr(16'h0200 + 16'(i), 8'h20 + 8'(i), 4);
        chk("full_no_ovf", overflow, 1'b0);
        tick();
        gpio_in = {1'b0, 8'h2F, 16'h02FF};
        tick();
        gpio_in = {1'b1, 8'h2F, 16'h02FF};
        model_push(16'h02FF, 8'h2F, 1'b1);
        tick();
        tick();
        ready = 1'b1;
        drain("simul_drain");
        chk("simul_overflow", overflow, 1'b0);
        chk("simul_wr_count", wr_count, 16'd5);

        // Trigger addresses
        run_seen = 0;
        halt_seen = 0;
        run_exp_n = 0;
        halt_exp_n = 0;
        wr(16'h0000, 8'h11, 4);
        wr(16'h0002, 8'h22, 4);
        wr(16'h0001, 8'h33, 4);
        drain("trig_drain");
        tick();
        chk("trig_run_count", run_seen, run_exp_n);
        chk("trig_halt_count", halt_seen, halt_exp_n);

        // Back-to-back trigger handshakes
        ready = 1'b0;
        run_seen = 0;
        run_exp_n = 0;
        wr(16'h0000, 8'h01, 4);
        wr(16'h0000, 8'h02, 4);
        ready = 1'b1;
        drain("b2b_drain");
        tick();
        chk("b2b_run_count", run_seen, run_exp_n);

        // Reset mid-operation discards pending entries
        ready = 1'b0;
        wr(16'h0300, 8'h30, 4);
        wr(16'h0301, 8'h31, 4);
        do_reset();
        ready = 1'b1;
        repeat (10) tick();
        chk("midrst_valid", reg_wr_valid, 1'b0);
        chk("midrst_wr_count", wr_count, 16'h0000);

        // Strobe held high across reset
        gpio_in = {1'b1, 8'h5A, 16'h0002};
        do_reset();
        repeat (10) tick();
        chk("strobe_hi_rst_count", wr_count, 16'h0000);
        chk("strobe_hi_rst_valid", reg_wr_valid, 1'b0);
        wr(16'h1234, 8'h77, 4);
        drain("rearm_drain");
        chk("rearm_wr_count", wr_count, m_cnt);

        // Strobe held for 100 cycles yields one command
        wr(16'h0040, 8'h99, 100);
        drain("held_drain");
        chk("held_wr_count", wr_count, m_cnt);

        // Randomized traffic with random backpressure
        rand_ready = 1'b1;
        for (int i = 0; i < 60; i++) begin
            n = 0;
            while (exp_q.size() >= DEPTH && n < 200) begin
                tick();
                n++;
            end
            case ($urandom_range(0, 3))
                0: a = 16'h0000;
                1: a = 16'h0002;
                2: a = 16'h0001;
                default: a = 16'($urandom);
            endcase
            wr(a, 8'($urandom), $urandom_range(3, 6));
        end
        rand_ready = 1'b0;
        ready = 1'b1;
        drain("rand_drain");
        chk("rand_wr_count", wr_count, m_cnt);
        chk("rand_overflow", overflow, m_ovf);

        // Counter wrap from FFFF
        tick();
        force dut.wr_cnt = 16'hFFFF;
        tick();
        release dut.wr_cnt;
        m_cnt = 16'hFFFF;
        tick();
        chk("wrap_preload", wr_count, m_cnt);
        wr(16'h0500, 8'h05, 4);
        drain("wrap_drain");
        chk("wrap_wr_count", wr_count, m_cnt);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
